// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM controller with shadowed per-channel config and debounced buttons.
// Define LED_PWM_BREATHE_EN to build the BREATHE ramp; otherwise mode 11 behaves as ON.
module led_pwm_ctrl #(
    parameter int unsigned CHANNELS      = 3,
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned LOG2DELAY     = 21,
    parameter int unsigned BUTTONS       = 2,
    parameter int unsigned DEBOUNCE_LOG2 = 16,
    localparam int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clki,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    input  logic [BUTTONS-1:0]  btn_n,
    output logic [CHANNELS-1:0] pwm,
    output logic [BUTTONS-1:0]  btn_state,
    output logic [BUTTONS-1:0]  btn_press,
    output logic                tick
);
    localparam logic [1:0] ModeOff     = 2'b00;
    localparam logic [1:0] ModeOn      = 2'b01;
    localparam logic [1:0] ModeBlink   = 2'b10;
    localparam logic [1:0] ModeBreathe = 2'b11;

    logic [LOG2DELAY-1:0]                r_presc;
    logic                                r_tick;
    logic [PWM_BITS-1:0]                 r_pcnt;
    logic                                r_phase;
    logic [CHANNELS-1:0][1:0]            r_sh_mode;
    logic [CHANNELS-1:0][1:0]            r_ac_mode;
    logic [CHANNELS-1:0][PWM_BITS-1:0]   r_sh_duty;
    logic [CHANNELS-1:0][PWM_BITS-1:0]   r_ac_duty;
    logic [CHANNELS-1:0]                 r_pwm;
    logic [CHANNELS-1:0][PWM_BITS-1:0]   w_level;
    logic [CHANNELS-1:0][PWM_BITS-1:0]   w_breathe;
    logic                                w_tick_evt;
    logic                                w_bound;
    logic                                w_wr;

    logic [BUTTONS-1:0]                     r_sync1;
    logic [BUTTONS-1:0]                     r_sync2;
    logic [BUTTONS-1:0]                     r_state;
    logic [BUTTONS-1:0]                     r_press;
    logic [BUTTONS-1:0][DEBOUNCE_LOG2-1:0]  r_db_cnt;

    // Tick event is the all-ones prescaler cycle; the tick output is its registered copy.
    assign w_tick_evt = &r_presc;
    assign w_bound    = &r_pcnt;
    assign w_wr       = cfg_we && (32'(cfg_ch) < CHANNELS);

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_tick    <= 1'b0;
            r_pcnt    <= '0;
            r_phase   <= 1'b0;
            r_sh_mode <= '0;
            r_ac_mode <= '0;
            r_sh_duty <= '0;
            r_ac_duty <= '0;
            r_pwm     <= '0;
        end else begin
            r_presc <= r_presc + LOG2DELAY'(1);
            r_tick  <= w_tick_evt;
            r_pcnt  <= r_pcnt + PWM_BITS'(1);
            if (w_tick_evt) begin
                r_phase <= ~r_phase;
            end
            if (w_wr) begin
                r_sh_mode[cfg_ch] <= cfg_mode;
                r_sh_duty[cfg_ch] <= cfg_duty;
            end
            if (w_bound) begin
                r_ac_mode <= r_sh_mode;
                r_ac_duty <= r_sh_duty;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                r_pwm[i] <= (w_level[i] > r_pcnt);
            end
        end
    end

`ifdef LED_PWM_BREATHE_EN
    logic [PWM_BITS-1:0] r_ramp;
    logic                r_ramp_down;

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            r_ramp      <= '0;
            r_ramp_down <= 1'b0;
        end else if (w_tick_evt) begin
            if (!r_ramp_down) begin
                if (&r_ramp) begin
                    r_ramp_down <= 1'b1;
                    r_ramp      <= r_ramp - PWM_BITS'(1);
                end else begin
                    r_ramp <= r_ramp + PWM_BITS'(1);
                end
            end else if (r_ramp == '0) begin
                r_ramp_down <= 1'b0;
                r_ramp      <= r_ramp + PWM_BITS'(1);
            end else begin
                r_ramp <= r_ramp - PWM_BITS'(1);
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_breathe
        logic [2*PWM_BITS-1:0] w_prod;
        assign w_prod       = {{PWM_BITS{1'b0}}, r_ramp} * {{PWM_BITS{1'b0}}, r_ac_duty[g]};
        assign w_breathe[g] = w_prod[2*PWM_BITS-1:PWM_BITS];
    end
`else
    assign w_breathe = r_ac_duty;
`endif

    always_comb begin
        w_level = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (r_ac_mode[i])
                ModeOff:     w_level[i] = '0;
                ModeOn:      w_level[i] = r_ac_duty[i];
                ModeBlink:   w_level[i] = r_phase ? r_ac_duty[i] : '0;
                ModeBreathe: w_level[i] = w_breathe[i];
                default:     w_level[i] = '0;
            endcase
        end
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_state  <= '0;
            r_press  <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
            for (int b = 0; b < BUTTONS; b++) begin
                r_press[b] <= 1'b0;
                if ((!r_sync2[b]) == r_state[b]) begin
                    r_db_cnt[b] <= '0;
                end else if (&r_db_cnt[b]) begin
                    r_state[b]  <= ~r_state[b];
                    r_press[b]  <= ~r_state[b];
                    r_db_cnt[b] <= '0;
                end else begin
                    r_db_cnt[b] <= r_db_cnt[b] + DEBOUNCE_LOG2'(1);
                end
            end
        end
    end

    assign pwm       = r_pwm;
    assign tick      = r_tick;
    assign btn_state = r_state;
    assign btn_press = r_press;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Scoreboard bench for led_pwm_ctrl: stimulus queues expected high-counts over cycle windows,
// a negedge monitor accumulates DUT outputs and compares when each window closes.
module tb_led_pwm_ctrl;
    localparam int unsigned CHANNELS      = 3;
    localparam int unsigned PWM_BITS      = 4;
    localparam int unsigned LOG2DELAY     = 3;
    localparam int unsigned BUTTONS       = 2;
    localparam int unsigned DEBOUNCE_LOG2 = 2;

    localparam int SigPwm0   = 0;
    localparam int SigPwm1   = 1;
    localparam int SigPwm2   = 2;
    localparam int SigState0 = 3;
    localparam int SigState1 = 4;
    localparam int SigPress0 = 5;
    localparam int SigPress1 = 6;
    localparam int SigTick   = 7;

    localparam int MOn      = 1;
    localparam int MBlink   = 2;
    localparam int MBreathe = 3;

    typedef struct {
        string name;
        int    sig;
        int    start;
        int    len;
        int    exp;
        int    acc;
    } chk_t;

    logic                clki     = 1'b0;
    logic                rst_n    = 1'b0;
    logic                cfg_we   = 1'b0;
    logic [1:0]          cfg_ch   = 2'd0;
    logic [1:0]          cfg_mode = 2'd0;
    logic [PWM_BITS-1:0] cfg_duty = '0;
    logic [BUTTONS-1:0]  btn_n    = 2'b11;
    logic [CHANNELS-1:0] pwm;
    logic [BUTTONS-1:0]  btn_state;
    logic [BUTTONS-1:0]  btn_press;
    logic                tick;
    logic [7:0]          obs;

    chk_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    // Clock edges since reset release: at the negedge with cyc == k the DUT has seen k edges.
    int   cyc     = -5;

    led_pwm_ctrl #(
        .CHANNELS      (CHANNELS),
        .PWM_BITS      (PWM_BITS),
        .LOG2DELAY     (LOG2DELAY),
        .BUTTONS       (BUTTONS),
        .DEBOUNCE_LOG2 (DEBOUNCE_LOG2)
    ) dut (
        .clki      (clki),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_duty  (cfg_duty),
        .btn_n     (btn_n),
        .pwm       (pwm),
        .btn_state (btn_state),
        .btn_press (btn_press),
        .tick      (tick)
    );

    always #5 clki = ~clki;
    always @(posedge clki) cyc <= cyc + 1;
    assign obs = {tick, btn_press, btn_state, pwm};

    always @(negedge clki) begin
        chk_t c;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            c = sb[i];
            if (cyc >= c.start && cyc < c.start + c.len) begin
                if (obs[c.sig] === 1'b1) c.acc++;
                sb[i] = c;
                if (cyc == c.start + c.len - 1) begin
                    n_tests++;
                    if (c.acc != c.exp) begin
                        n_fail++;
                        $display("FAIL %s: high count %0d, expected %0d (cycles %0d..%0d)",
                                 c.name, c.acc, c.exp, c.start, c.start + c.len - 1);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    task automatic expect_cnt(input string name, input int sig, input int start, input int len,
                              input int exp);
        sb.push_back('{name, sig, start, len, exp, 0});
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clki);
    endtask

    task automatic cfg_write(input int at, input int ch, input int mode, input int duty);
        wait_cyc(at);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = PWM_BITS'(duty);
        wait_cyc(at + 1);
        cfg_we   = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 8; s++) expect_cnt($sformatf("reset_sig%0d", s), s, -3, 3, 0);
        wait_cyc(0);
        n_tests++;
        if (pwm !== '0) begin
            n_fail++;
            $display("FAIL reset_pwm: %b", pwm);
        end
        n_tests++;
        if (btn_state !== '0) begin
            n_fail++;
            $display("FAIL reset_btn_state: %b", btn_state);
        end
        n_tests++;
        if (btn_press !== '0) begin
            n_fail++;
            $display("FAIL reset_btn_press: %b", btn_press);
        end
        n_tests++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tick: %b", tick);
        end
        rst_n = 1'b1;

        expect_cnt("tick_total", SigTick, 1, 32, 4);
        expect_cnt("tick_first", SigTick, 8, 1, 1);
        expect_cnt("tick_gap", SigTick, 9, 7, 0);
        for (int s = 0; s < 3; s++) expect_cnt($sformatf("pwm%0d_idle", s), s, 1, 32, 0);

        expect_cnt("on_pre_boundary", SigPwm0, 33, 16, 0);
        expect_cnt("on_duty4_p3", SigPwm0, 49, 16, 4);
        expect_cnt("on_duty4_p4_midwrite", SigPwm0, 65, 16, 4);
        expect_cnt("on_duty12_last_wins", SigPwm0, 81, 16, 12);
        expect_cnt("ignored_write_ch0", SigPwm0, 97, 16, 12);
        expect_cnt("on_duty12_pre_breathe", SigPwm0, 129, 16, 12);
        expect_cnt("on_duty0_ch1", SigPwm1, 49, 64, 0);
        expect_cnt("ch2_off_until_blink", SigPwm2, 49, 64, 0);
        cfg_write(33, 0, MOn, 4);
        cfg_write(35, 1, MOn, 0);
        cfg_write(70, 0, MOn, 9);
        cfg_write(74, 0, MOn, 12);
        cfg_write(90, 3, MOn, 15);

        expect_cnt("blink_off_a", SigPwm2, 113, 8, 0);
        expect_cnt("blink_on_a", SigPwm2, 121, 8, 7);
        expect_cnt("blink_off_b", SigPwm2, 129, 8, 0);
        expect_cnt("blink_on_b", SigPwm2, 137, 8, 7);
        cfg_write(100, 2, MBlink, 15);

`ifdef LED_PWM_BREATHE_EN
        expect_cnt("breathe_r12", SigPwm0, 145, 8, 8);
        expect_cnt("breathe_r11", SigPwm0, 153, 8, 2);
        expect_cnt("breathe_r2", SigPwm0, 225, 8, 1);
        expect_cnt("breathe_r1", SigPwm0, 233, 8, 0);
        expect_cnt("breathe_r0", SigPwm0, 241, 8, 0);
        expect_cnt("breathe_r1_up", SigPwm0, 249, 8, 0);
        expect_cnt("breathe_r2_up", SigPwm0, 257, 8, 1);
        expect_cnt("breathe_r14_up", SigPwm0, 353, 8, 8);
        expect_cnt("breathe_r15_peak", SigPwm0, 361, 8, 6);
        expect_cnt("breathe_r13_down", SigPwm0, 377, 8, 4);
`else
        expect_cnt("mode11_as_on_a", SigPwm0, 145, 8, 8);
        expect_cnt("mode11_as_on_b", SigPwm0, 153, 8, 7);
        expect_cnt("mode11_as_on_c", SigPwm0, 225, 8, 8);
        expect_cnt("mode11_as_on_d", SigPwm0, 233, 8, 7);
        expect_cnt("mode11_as_on_e", SigPwm0, 241, 8, 8);
        expect_cnt("mode11_as_on_f", SigPwm0, 249, 8, 7);
        expect_cnt("mode11_as_on_g", SigPwm0, 257, 8, 8);
        expect_cnt("mode11_as_on_h", SigPwm0, 353, 8, 8);
        expect_cnt("mode11_as_on_i", SigPwm0, 361, 8, 7);
        expect_cnt("mode11_as_on_j", SigPwm0, 377, 8, 7);
`endif
        cfg_write(140, 0, MBreathe, 15);

        expect_cnt("btn0_glitch_and_latency", SigState0, 400, 26, 0);
        expect_cnt("btn0_pressed", SigState0, 426, 20, 20);
        expect_cnt("btn0_released", SigState0, 446, 10, 0);
        expect_cnt("press0_none_early", SigPress0, 400, 26, 0);
        expect_cnt("press0_pulse", SigPress0, 426, 1, 1);
        expect_cnt("press0_none_release", SigPress0, 427, 33, 0);
        expect_cnt("btn1_idle", SigState1, 400, 60, 0);
        expect_cnt("press1_idle", SigPress1, 400, 60, 0);
        wait_cyc(400);
        btn_n = 2'b10;
        wait_cyc(402);
        btn_n = 2'b11;
        wait_cyc(420);
        btn_n = 2'b10;
        wait_cyc(440);
        btn_n = 2'b11;

        wait_cyc(465);
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clki);
        while (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: window never closed, expected %0d", sb[0].name, sb[0].exp);
            sb.delete(0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pwm_ctrl.md
# led_pwm_ctrl

Parametrised multi-channel LED PWM controller with debounced button inputs, the successor to the fixed three-colour blink logic. Each channel has a mode of OFF, ON, BLINK or BREATHE and a PWM duty, both set through a simple configuration write port. Per-channel PWM outputs drive the `RGBnPWM` inputs of the `SB_RGBA_DRV` hard macro at top level. Debounced button state and press pulses go to user logic.

## Interface
Parameters:
- `CHANNELS`, 3: number of PWM channels (1–8).
- `PWM_BITS`, 8: duty/PWM counter width (2–12).
- `LOG2DELAY`, 21: tick period is 2**LOG2DELAY clocks (≥2).
- `BUTTONS`, 2: number of button inputs (1–4).
- `DEBOUNCE_LOG2`, 16: a button must be stable for 2**DEBOUNCE_LOG2 clocks (≥1).

Ports:
- `clki`  in  1  system clock (already global-buffered); all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cfg_we`  in  1  config write strobe, one cycle per write.
- `cfg_ch`  in  max(1,clog2(CHANNELS))  target channel.
- `cfg_mode`  in  2  00 OFF, 01 ON, 10 BLINK, 11 BREATHE.
- `cfg_duty`  in  PWM_BITS  channel duty.
- `btn_n`  in  BUTTONS  raw button pins, active low, asynchronous.
- `pwm`  out  CHANNELS  registered PWM outputs, 1 = LED on.
- `btn_state`  out  BUTTONS  debounced level, 1 = pressed.
- `btn_press`  out  BUTTONS  one-cycle pulse on each debounced press.
- `tick`  out  1  one-cycle pulse every 2**LOG2DELAY clocks.

## Operation
- Reset values:
  - `pwm`, `btn_state`, `btn_press`, `tick` = 0.
  - All modes OFF, all duties 0 (shadow and active copies).
  - Prescaler, PWM counter and ramp = 0; ramp direction up; blink phase 0.
  - Synchronisers reset to 1 (released); debounce counters 0.
- Prescaler: a LOG2DELAY-bit free-running counter. `tick` = 1 in the cycle after the counter is all-ones.
- PWM counter: `pcnt` is PWM_BITS wide, free-running, wraps from 2**PWM_BITS−1 to 0. Period boundary = the cycle where `pcnt` is all-ones.
- Config writes:
  - `cfg_we` with `cfg_ch` < CHANNELS loads the shadow mode and shadow duty for that channel.
  - A write with `cfg_ch` ≥ CHANNELS is ignored.
  - Shadow copies move to the active copies at the period boundary only, so updates are glitch-free.
  - If several writes land in one period, the last write wins.
- Per-channel level:
  - OFF: 0.
  - ON: duty.
  - BLINK: duty when phase = 1, else 0. The phase is shared by all channels and toggles on each `tick`.
  - BREATHE: (ramp × duty) >> PWM_BITS, full-width product, truncated.
- Compare: `pwm[i]` <= (level_i > `pcnt`).
  - Duty 0 gives a constant 0.
  - Duty 2**PWM_BITS−1 gives 1 for all but one cycle per period.
- Ramp (shared by all channels, PWM_BITS wide) steps by ±1 on each `tick`:
  - At all-ones while going up, the direction flips to down and the next tick gives max−1.
  - At 0 while going down, the direction flips to up.
  - Full breath = 2·(2**PWM_BITS−1) ticks.
- Buttons: per bit, a 2-flop synchroniser feeds a debounce counter.
  - The counter clears whenever the synchronised value equals the current `btn_state`; otherwise it increments.
  - When the count reaches 2**DEBOUNCE_LOG2−1, `btn_state` toggles and the counter clears.
  - `btn_press` pulses in the same cycle that `btn_state` goes 0→1. There is no pulse on release.
- A `tick` and a period boundary in the same cycle are both processed. The blink phase and ramp update, and the new active duty is used from the next compare.

## Timing
- PWM output latency: `pwm` reflects the compare of `pcnt` with one clock of register delay.
- Config write latency:
  - A write in cycle t is visible in the shadow copy at t+1.
  - It becomes active at the first period boundary ≥ t+1.
  - It affects `pwm` from the following period onward.
- Button latency: a clean edge on `btn_n` reaches `btn_state` 2 (sync) + 2**DEBOUNCE_LOG2 clocks later.
- Bounce rejection: a glitch shorter than 2**DEBOUNCE_LOG2 clocks leaves `btn_state` unchanged.
- Reset: asserting `rst_n` mid-operation forces all reset values immediately, asynchronously.
  - Release is synchronous in effect; the first counter increments occur on the first clock edge after deassertion.

## Configuration
- Macro: `LED_PWM_BREATHE_EN`.
- Defined: the BREATHE mode, ramp register, direction flag and multiplier are present, and mode 11 behaves as described above.
- Undefined:
  - The ramp and multiplier are not built.
  - Mode 11 behaves exactly as ON, with level = duty.
  - All other behaviour is unchanged.

## Test plan
Bench parameters: CHANNELS=3, PWM_BITS=4, LOG2DELAY=3, BUTTONS=2, DEBOUNCE_LOG2=2.
- Reset: hold `rst_n`=0 with `btn_n`=11 → `pwm`=000, `btn_state`=00, `btn_press`=00, `tick`=0. Release → `tick` pulses every 8 clocks.
- ON mode:
  - Write ch0, ON, duty 4 → after the next boundary, `pwm[0]` is high exactly 4 of every 16 clocks; `pwm[2:1]`=0.
  - Write ch1, ON, duty 0 → `pwm[1]` stays constantly 0.
- Update timing: change ch0 duty from 4 to 12 mid-period → the current period still shows 4 high cycles; the next period shows 12.
- BLINK: write ch2, BLINK, duty 15 → `pwm[2]` alternates 8 clocks off-envelope / 8 clocks on-envelope. During on-envelope it is low for only 1 cycle per 16-cycle period.
- BREATHE (macro defined): write ch0, BREATHE, duty 15 → ramp reaches 15 after 15 ticks, then falls to 0 after 15 more. With the macro undefined, `pwm[0]` matches ON duty 15.
- Buttons and ignored writes:
  - Drive `btn_n[0]` low for 2 clocks then high → no change.
  - Drive it low and hold → `btn_state[0]`=1 and exactly one `btn_press[0]` pulse, 6 clocks after the edge.
  - A write with `cfg_ch`=3 leaves all channels unchanged.
